// File: rtl/sp_ram_arb_pkg.sv
// Shared constants and helpers for the single-port RAM arbiter.
// Pure definitions: no logic, no latency, no flow control.
package sp_ram_arb_pkg;

  localparam int MAX_PORTS = 8;

  // Index width for n items, never below 1 so a 1-entry index is still a legal vector.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search begins one past the last winner, wrapping.
// Latency 0; no backpressure, losers simply see gnt low and keep requesting.
module rr_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IW = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IW-1:0]        gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    // Offset 1..NUM_PORTS from last, so last itself is checked only after everyone else.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = IW'((int'(last) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = found;
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM among NUM_PORTS requesters, one access per cycle, round-robin.
// Latency: grant 0 cycles, rvalid 1 cycle after grant; backpressure: a port holds req until granted.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rstn_i,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0]                 we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]                 gnt_o,
  output logic [NUM_PORTS-1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 ram_en_o,
  output logic [ADDR_WIDTH-1:0]                ram_addr_o,
  output logic                                 ram_we_o,
  output logic [DATA_WIDTH/8-1:0]              ram_be_o,
  output logic [DATA_WIDTH-1:0]                ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                ram_rdata_i
);

  localparam int IW = idx_width(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
    $error("sp_ram_arbiter: NUM_PORTS must be within 2..MAX_PORTS");
  end

  logic [NUM_PORTS-1:0] req_eff;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 any_gnt;
  logic [IW-1:0]        last_q, last_d;
  logic [NUM_PORTS-1:0] resp_q, resp_d;

  // Requests are masked while reset is held so nothing reaches the RAM during reset.
  assign req_eff = req_i & {NUM_PORTS{rstn_i}};

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arbiter (
    .req     (req_eff),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign any_gnt = |arb_gnt;

  always_comb begin
    last_d = any_gnt ? arb_idx : last_q;
    resp_d = arb_gnt;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= IW'(NUM_PORTS - 1);
      resp_q <= '0;
    end else begin
      last_q <= last_d;
      resp_q <= resp_d;
    end
  end

  always_comb begin
    ram_en_o    = any_gnt;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (any_gnt) begin
      ram_addr_o  = addr_i[arb_idx];
      ram_we_o    = we_i[arb_idx];
      ram_be_o    = be_i[arb_idx];
      ram_wdata_o = wdata_i[arb_idx];
    end
  end

  assign gnt_o    = arb_gnt;
  assign rvalid_o = resp_q;
  assign rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios plus randomized traffic against a
// behavioural round-robin / memory model, with a simple RAM behind the arbiter.
module tb_sp_ram_arbiter;

  localparam int NP = 2;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic                    clk = 1'b0;
  logic                    rstn_i = 1'b0;
  logic [NP-1:0]           req_i = '0;
  logic [NP-1:0][AW-1:0]   addr_i = '0;
  logic [NP-1:0]           we_i = '0;
  logic [NP-1:0][BW-1:0]   be_i = '0;
  logic [NP-1:0][DW-1:0]   wdata_i = '0;
  logic [NP-1:0]           gnt_o;
  logic [NP-1:0]           rvalid_o;
  logic [DW-1:0]           rdata_o;
  logic                    ram_en_o;
  logic [AW-1:0]           ram_addr_o;
  logic                    ram_we_o;
  logic [BW-1:0]           ram_be_o;
  logic [DW-1:0]           ram_wdata_o;
  logic [DW-1:0]           ram_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  sp_ram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // RAM behind the arbiter, driven only by the DUT's RAM-side outputs.
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  logic [DW-1:0] ram_old;
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_old = ram_mem.exists(ram_addr_o) ? ram_mem[ram_addr_o] : '0;
      if (ram_we_o) ram_mem[ram_addr_o] = merge(ram_old, ram_wdata_o, ram_be_o);
      else          ram_rdata_i <= ram_old;
    end
  end

  // Reference model, driven only by the bench's own stimulus.
  int            m_last;
  logic [NP-1:0] m_rvalid;
  bit            m_rd_chk;
  logic [DW-1:0] m_rdata_exp;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_old;
  int            m_p;

  function automatic int exp_idx();
    if (!rstn_i) return -1;
    for (int i = 1; i <= NP; i++) begin
      if (req_i[(m_last + i) % NP]) return (m_last + i) % NP;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      m_last   = NP - 1;
      m_rvalid = '0;
      m_rd_chk = 1'b0;
    end else begin
      m_p      = exp_idx();
      m_rvalid = onehot(m_p);
      m_rd_chk = 1'b0;
      if (m_p >= 0) begin
        m_last  = m_p;
        ref_old = ref_mem.exists(addr_i[m_p]) ? ref_mem[addr_i[m_p]] : '0;
        if (we_i[m_p]) ref_mem[addr_i[m_p]] = merge(ref_old, wdata_i[m_p], be_i[m_p]);
        else begin
          m_rd_chk    = 1'b1;
          m_rdata_exp = ref_old;
        end
      end
    end
  end

  task automatic do_reset();
    rstn_i = 1'b0;
    req_i  = '0;
    we_i   = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    req_i = 2'b11; we_i = 2'b11; be_i = '1;
    addr_i[0] = 15'h123; addr_i[1] = 15'h456;
    wdata_i[0] = 32'h1234_5678; wdata_i[1] = 32'h8765_4321;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (gnt_o !== '0 || rvalid_o !== '0 || ram_en_o !== 1'b0 || ram_addr_o !== '0 ||
          ram_we_o !== 1'b0 || ram_be_o !== '0 || ram_wdata_o !== '0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b rvalid=%b en=%b addr=%h we=%b be=%h wdata=%h, required all 0",
                 gnt_o, rvalid_o, ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o);
      end
    end
    @(posedge clk); #1 rstn_i = 1'b1; we_i = '0;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01) begin errors++; $display("FAIL reset_first_gnt: got %b required 01", gnt_o); end
    @(posedge clk); #1 req_i = '0;
    @(negedge clk);
    checks++;
    if (rvalid_o !== 2'b01) begin errors++; $display("FAIL reset_first_rvalid: got %b required 01", rvalid_o); end
  endtask

  task automatic test_rotation();
    logic [NP-1:0] seq [6];
    logic [NP-1:0] prev;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    we_i = '0;
    req_i = 2'b11;
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_o !== seq[c]) begin errors++; $display("FAIL rotation_gnt[%0d]: got %b required %b", c, gnt_o, seq[c]); end
      checks++;
      if (rvalid_o !== prev) begin errors++; $display("FAIL rotation_rvalid[%0d]: got %b required %b", c, rvalid_o, prev); end
      prev = seq[c];
      @(posedge clk); #1;
    end
    req_i = '0;
    @(negedge clk);
    checks++;
    if (rvalid_o !== 2'b10) begin errors++; $display("FAIL rotation_rvalid_tail: got %b required 10", rvalid_o); end
  endtask

  task automatic test_write_read();
    do_reset();
    req_i = 2'b10; we_i = 2'b10; addr_i[1] = 15'h40; be_i[1] = 4'hF; wdata_i[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b10 || ram_en_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 15'h40 ||
        ram_wdata_o !== 32'hDEAD_BEEF || ram_be_o !== 4'hF) begin
      errors++;
      $display("FAIL wr_drive: gnt=%b en=%b we=%b addr=%h wdata=%h be=%h required 10/1/1/0040/deadbeef/f",
               gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o);
    end
    @(posedge clk); #1 req_i = 2'b01; we_i = 2'b00; addr_i[0] = 15'h40; be_i[0] = 4'hF;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01 || rvalid_o !== 2'b10 || ram_we_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: gnt=%b rvalid=%b we=%b required 01/10/0", gnt_o, rvalid_o, ram_we_o);
    end
    @(posedge clk); #1 req_i = '0;
    @(negedge clk);
    checks++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_data: rvalid=%b rdata=%h required 01/deadbeef", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_byte_write();
    do_reset();
    req_i = 2'b01; we_i = 2'b01; addr_i[0] = 15'h80; be_i[0] = 4'hF; wdata_i[0] = 32'hAABB_CCDD;
    @(posedge clk); #1 be_i[0] = 4'b0001; wdata_i[0] = 32'h0000_0011;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01 || ram_be_o !== 4'b0001) begin
      errors++;
      $display("FAIL byte_wr_drive: gnt=%b be=%b required 01/0001", gnt_o, ram_be_o);
    end
    @(posedge clk); #1 we_i = '0; be_i[0] = 4'hF;
    @(posedge clk); #1 req_i = '0;
    @(negedge clk);
    checks++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'hAABB_CC11) begin
      errors++;
      $display("FAIL byte_rd_data: rvalid=%b rdata=%h required 01/aabbcc11", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    we_i = '0;
    req_i = 2'b11;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01) begin errors++; $display("FAIL withdraw_gnt0: got %b required 01", gnt_o); end
    @(posedge clk); #1 req_i = '0;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00 || rvalid_o !== 2'b01 || ram_en_o !== 1'b0 || ram_addr_o !== '0) begin
      errors++;
      $display("FAIL withdraw_idle: gnt=%b rvalid=%b en=%b addr=%h required 00/01/0/0", gnt_o, rvalid_o, ram_en_o, ram_addr_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rvalid_o !== 2'b00) begin errors++; $display("FAIL withdraw_no_rvalid: got %b required 00", rvalid_o); end
    @(posedge clk); #1 req_i = 2'b11;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b10) begin errors++; $display("FAIL withdraw_next_winner: got %b required 10", gnt_o); end
    @(posedge clk); #1 req_i = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 2'b01; we_i = '0; addr_i[0] = 15'h40;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01) begin errors++; $display("FAIL midrst_gnt: got %b required 01", gnt_o); end
    @(posedge clk); #1 req_i = '0; rstn_i = 1'b0;
    #1;
    checks++;
    if (rvalid_o !== 2'b00) begin errors++; $display("FAIL midrst_rvalid_drop: got %b required 00", rvalid_o); end
    @(negedge clk);
    checks++;
    if (rvalid_o !== 2'b00) begin errors++; $display("FAIL midrst_rvalid_held: got %b required 00", rvalid_o); end
    @(posedge clk); #1 rstn_i = 1'b1; req_i = 2'b11;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01 || rvalid_o !== 2'b00) begin
      errors++;
      $display("FAIL midrst_after: gnt=%b rvalid=%b required 01/00", gnt_o, rvalid_o);
    end
    @(posedge clk); #1 req_i = '0;
  endtask

  task automatic test_random();
    int eidx;
    int prev_idx;
    int waits [NP];
    logic [NP-1:0] eg;
    do_reset();
    prev_idx = -1;
    for (int p = 0; p < NP; p++) waits[p] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req_i[p] && prev_idx != p && $urandom_range(0, 9) < 8)) begin
          req_i[p]   = ($urandom_range(0, 2) != 0);
          we_i[p]    = $urandom_range(0, 1) == 1;
          addr_i[p]  = AW'($urandom_range(0, 15) * 4);
          be_i[p]    = BW'($urandom);
          wdata_i[p] = $urandom;
        end
      end
      @(negedge clk);
      eidx = exp_idx();
      eg   = onehot(eidx);
      checks++;
      if (gnt_o !== eg || rvalid_o !== m_rvalid || ram_en_o !== (eidx >= 0)) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: gnt=%b rvalid=%b en=%b required %b/%b/%b",
                 c, gnt_o, rvalid_o, ram_en_o, eg, m_rvalid, eidx >= 0);
      end
      if (eidx >= 0) begin
        checks++;
        if (ram_addr_o !== addr_i[eidx] || ram_we_o !== we_i[eidx] || ram_be_o !== be_i[eidx] ||
            ram_wdata_o !== wdata_i[eidx]) begin
          errors++;
          $display("FAIL rand_mux[%0d]: addr=%h we=%b be=%h wdata=%h required %h/%b/%h/%h", c,
                   ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, addr_i[eidx], we_i[eidx], be_i[eidx], wdata_i[eidx]);
        end
      end else begin
        checks++;
        if (ram_addr_o !== '0 || ram_we_o !== 1'b0 || ram_be_o !== '0 || ram_wdata_o !== '0) begin
          errors++;
          $display("FAIL rand_idle_zero[%0d]: addr=%h we=%b be=%h wdata=%h required 0", c,
                   ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o);
        end
      end
      if (m_rd_chk) begin
        checks++;
        if (rdata_o !== m_rdata_exp) begin
          errors++;
          $display("FAIL rand_rdata[%0d]: got %h required %h", c, rdata_o, m_rdata_exp);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (req_i[p] && gnt_o[p] !== 1'b1) waits[p]++;
        else waits[p] = 0;
        if (req_i[p]) begin
          checks++;
          if (waits[p] > NP - 1) begin
            errors++;
            $display("FAIL rand_fairness[%0d]: port %0d waited %0d grants, allowed %0d", c, p, waits[p], NP - 1);
          end
        end
      end
      prev_idx = eidx;
      @(posedge clk); #1;
    end
    req_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_write_read();
    test_byte_write();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
